// File: rtl/aes_cipher_rounds.sv
// Iterative AES encryption core: one round per clock over a 1920-bit key schedule.
// SubWord is the 4-byte S-box stage shared with key expansion.
module aes_subword (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 by an addition chain, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] v;
    t = gmul(gmul(x, x), x);
    t = gmul(gmul(t, t), x);
    t = gmul(gmul(t, t), x);
    t = gmul(gmul(t, t), x);
    t = gmul(gmul(t, t), x);
    t = gmul(gmul(t, t), x);
    v = gmul(t, t);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

module aes_cipher_rounds (
  input  logic          clk,
  input  logic          reset,
  input  logic [1919:0] w,
  input  logic [7:0]    Nk,
  input  logic          keyReady,
  input  logic          start,
  input  logic [127:0]  plaintext,
  output logic [127:0]  ciphertext,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, ROUND} state_t;

  state_t        r_fsm;
  logic [127:0]  r_st;
  logic [3:0]    r_round;
  logic [3:0]    r_nr;

  logic [3:0]    w_nr;
  logic [127:0]  w_rk [16];
  logic [127:0]  w_sb;
  logic [127:0]  w_sr;
  logic [127:0]  w_mc;
  logic [127:0]  w_next;
  logic          w_last;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  always_comb begin
    unique case (1'b1)
      (Nk == 8'd4): w_nr = 4'd10;
      (Nk == 8'd6): w_nr = 4'd12;
      default:      w_nr = 4'd14;
    endcase
  end

  always_comb begin
    w_rk[15] = '0;
    for (int i = 0; i < 15; i++)
      w_rk[i] = w[1919-128*i -: 128];
  end

  for (genvar c = 0; c < 4; c++) begin : g_sub
    aes_subword u_sw (
      .i_word (r_st[127-32*c -: 32]),
      .o_word (w_sb[127-32*c -: 32])
    );
  end

  // Byte k of the state is row k%4, column k/4.
  always_comb begin
    w_sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sr[127-8*(r+4*c) -: 8] = w_sb[127-8*(r+4*((c+r)%4)) -: 8];
  end

  always_comb begin
    w_mc = '0;
    for (int c = 0; c < 4; c++)
      w_mc[127-32*c -: 32] = mixcol(w_sr[127-32*c -: 32]);
  end

  assign w_last = (r_round == r_nr);
  assign w_next = (w_last ? w_sr : w_mc) ^ w_rk[r_round];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm      <= IDLE;
      r_st       <= '0;
      r_round    <= '0;
      r_nr       <= '0;
      ciphertext <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (start && keyReady) begin
            r_st    <= plaintext ^ w_rk[0];
            r_round <= 4'd1;
            r_nr    <= w_nr;
            r_fsm   <= ROUND;
            busy    <= 1'b1;
          end
        end
        ROUND: begin
          if (!keyReady) begin
            r_fsm <= IDLE;
            busy  <= 1'b0;
          end else begin
            r_st <= w_next;
            if (w_last) begin
              ciphertext <= w_next;
              done       <= 1'b1;
              busy       <= 1'b0;
              r_fsm      <= IDLE;
            end else begin
              r_round <= r_round + 4'd1;
            end
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

endmodule
